uart_alu_ctrl: RTL and testbench

Frame sequencer between the UART FIFO pair and a combinational ALU. It pops three bytes from the RX FIFO in order: operand A, operand B, opcode. It drives the operands and opcode to the ALU, captures the result, and pushes one result byte into the TX FIFO. A per-frame inactivity timer discards partial frames when the host stalls. The block replaces the loopback user logic sitting on the rd_uart/wr_uart/r_data/w_data/rx_empty/tx_full interface.

---
 rtl/uart_alu_pkg.sv | 27 ++
 rtl/frame_timer.sv | 30 +++
 rtl/uart_alu_ctrl.sv | 135 +++++++++++++
 tb/tb_uart_alu_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-to-ALU frame sequencer: FSM state encoding and ALU opcodes.
package uart_alu_pkg;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4
    } state_e;

    localparam int unsigned NB_OPCODE = 6;

    localparam logic [NB_OPCODE-1:0] OP_ADD = 6'h20;
    localparam logic [NB_OPCODE-1:0] OP_SUB = 6'h22;
    localparam logic [NB_OPCODE-1:0] OP_AND = 6'h24;
    localparam logic [NB_OPCODE-1:0] OP_OR  = 6'h25;
    localparam logic [NB_OPCODE-1:0] OP_XOR = 6'h26;
    localparam logic [NB_OPCODE-1:0] OP_NOR = 6'h27;
    localparam logic [NB_OPCODE-1:0] OP_SRA = 6'h03;
    localparam logic [NB_OPCODE-1:0] OP_SRL = 6'h02;

    function automatic logic is_wait_operand(input state_e s);
        return (s == WAIT_B) || (s == WAIT_OP);
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Per-frame inactivity counter; expire is high while the count sits at TIMEOUT-1.
module frame_timer #(
    parameter int unsigned TIMEOUT = 5000000,
    parameter int unsigned TO_BITS = 23
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TO_BITS-1:0] LAST = TO_BITS'(TIMEOUT - 1);

    logic [TO_BITS-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    // TIMEOUT == 0 leaves the counter free-running but never lets it fire.
    assign expire = (TIMEOUT != 0) && (count_q == LAST);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer: pops A, B, opcode from the RX FIFO, runs the ALU, pushes one result byte.
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6,
    parameter int unsigned TIMEOUT = 5000000,
    parameter int unsigned TO_BITS = 23
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_empty,
    input  logic [NB_DATA-1:0] i_r_data,
    output logic               o_rd_uart,
    input  logic               i_tx_full,
    output logic               o_wr_uart,
    output logic [NB_DATA-1:0] o_w_data,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_busy,
    output logic               o_timeout
);

    state_e             state_q, state_d;
    logic [NB_DATA-1:0] a_q, a_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] res_q, res_d;
    logic               timeout_q, timeout_d;
    logic               timer_clear;
    logic               timer_enable;
    logic               timer_expire;
    logic               waiting;

    assign waiting      = is_wait_operand(state_q);
    assign timer_enable = waiting && i_rx_empty;

    frame_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_BITS (TO_BITS)
    ) u_frame_timer (
        .clk    (i_clk),
        .rst_n  (i_reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (timer_expire)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_d       = res_q;
        o_rd_uart   = 1'b0;
        o_wr_uart   = 1'b0;
        timer_clear = 1'b0;
        timeout_d   = timer_enable && timer_expire;

        case (state_q)
            WAIT_A: begin
                if (!i_rx_empty) begin
                    a_d         = i_r_data;
                    o_rd_uart   = 1'b1;
                    timer_clear = 1'b1;
                    state_d     = WAIT_B;
                end
            end
            WAIT_B: begin
                if (!i_rx_empty) begin
                    b_d         = i_r_data;
                    o_rd_uart   = 1'b1;
                    timer_clear = 1'b1;
                    state_d     = WAIT_OP;
                end else if (timer_expire) begin
                    state_d = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (!i_rx_empty) begin
                    op_d      = i_r_data[NB_OP-1:0];
                    o_rd_uart = 1'b1;
                    state_d   = EXEC;
                end else if (timer_expire) begin
                    state_d = WAIT_A;
                end
            end
            EXEC: begin
                res_d   = i_alu_result;
                state_d = SEND;
            end
            SEND: begin
                if (!i_tx_full) begin
                    o_wr_uart = 1'b1;
                    state_d   = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase

        // FIFO strobes are suppressed combinationally so nothing is lost in a reset cycle.
        if (!i_reset) begin
            o_rd_uart = 1'b0;
            o_wr_uart = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q   <= WAIT_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            res_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            res_q     <= res_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_alu_a   = a_q;
    assign o_alu_b   = b_q;
    assign o_alu_op  = op_q;
    assign o_w_data  = res_q;
    assign o_busy    = (state_q != WAIT_A);
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: queue-based FIFO models, stub ALU and a frame-level result model.
module tb_uart_alu_ctrl;

    localparam int unsigned TO = 16;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_rx_empty;
    logic [7:0] i_r_data;
    logic       i_tx_full;
    logic [7:0] i_alu_result;
    logic       o_rd_uart;
    logic       o_wr_uart;
    logic [7:0] o_w_data;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic       o_busy;
    logic       o_timeout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int to_cnt = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_got[$];
    logic [7:0] exp_q[$];
    int         pop_cyc[$];
    int         push_cyc[$];
    logic       hold_rx = 1'b0;
    logic       tx_full_flag = 1'b0;

    logic [31:0] s_rd, s_wr, s_wdata, s_busy, s_timeout, s_a, s_b, s_op;

    uart_alu_ctrl #(
        .NB_DATA (8),
        .NB_OP   (6),
        .TIMEOUT (TO),
        .TO_BITS (5)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_rx_empty   (i_rx_empty),
        .i_r_data     (i_r_data),
        .o_rd_uart    (o_rd_uart),
        .i_tx_full    (i_tx_full),
        .o_wr_uart    (o_wr_uart),
        .o_w_data     (o_w_data),
        .o_alu_a      (o_alu_a),
        .o_alu_b      (o_alu_b),
        .o_alu_op     (o_alu_op),
        .i_alu_result (i_alu_result),
        .o_busy       (o_busy),
        .o_timeout    (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return sa >>> b[2:0];
            6'h02:   return a >> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    assign i_alu_result = ref_alu(o_alu_a, o_alu_b, o_alu_op);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q8(input logic [7:0] q[$], input int i);
        if (i < q.size()) return 32'(q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] qi(input int q[$], input int i);
        if (i < q.size()) return 32'(q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    // Drive inputs from the FIFO models, sample just after, then advance one clock.
    task automatic step();
        i_rx_empty = (rx_q.size() == 0) || hold_rx;
        i_r_data   = 8'h00;
        if (rx_q.size() != 0) i_r_data = rx_q[0];
        i_tx_full  = tx_full_flag;
        #1;
        s_rd      = 32'(o_rd_uart);
        s_wr      = 32'(o_wr_uart);
        s_wdata   = 32'(o_w_data);
        s_busy    = 32'(o_busy);
        s_timeout = 32'(o_timeout);
        s_a       = 32'(o_alu_a);
        s_b       = 32'(o_alu_b);
        s_op      = 32'(o_alu_op);
        if (o_rd_uart === 1'b1 && !i_rx_empty) begin
            void'(rx_q.pop_front());
            pop_cyc.push_back(cyc);
        end
        if (o_wr_uart === 1'b1) begin
            tx_got.push_back(o_w_data);
            push_cyc.push_back(cyc);
        end
        if (o_timeout === 1'b1) to_cnt++;
        @(posedge i_clk);
        @(negedge i_clk);
        cyc++;
    endtask

    initial begin
        logic [5:0] ops [7];
        int         c0;
        int         n0;
        int         to0;
        int         guard;
        int         stall_run;
        logic [7:0] a, b;
        logic [5:0] op;
        int         exp_pops [6];
        int         exp_push [2];

        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03};
        exp_pops = '{0, 1, 2, 5, 6, 7};
        exp_push = '{4, 9};
        i_reset = 1'b0;
        i_rx_empty = 1'b1;
        i_r_data = 8'h00;
        i_tx_full = 1'b0;
        @(negedge i_clk);

        // Reset with data available: no pop, registers cleared.
        rx_q.push_back(8'h5A);
        repeat (3) step();
        check("reset_no_pop", s_rd, 0);
        check("reset_no_push", s_wr, 0);
        check("reset_rx_kept", rx_q.size(), 1);
        i_reset = 1'b1;
        hold_rx = 1'b1;
        step();
        check("reset_busy", s_busy, 0);
        check("reset_timeout", s_timeout, 0);
        check("reset_a", s_a, 0);
        check("reset_b", s_b, 0);
        check("reset_op", s_op, 0);
        check("reset_wdata", s_wdata, 0);
        rx_q.delete();
        hold_rx = 1'b0;
        to_cnt = 0;

        // Basic frame 05 + 03.
        pop_cyc.delete(); push_cyc.delete(); tx_got.delete();
        c0 = cyc;
        rx_q = '{8'h05, 8'h03, 8'h20};
        repeat (8) step();
        check("f1_pop_count", pop_cyc.size(), 3);
        check("f1_pop0_cycle", qi(pop_cyc, 0), 32'(c0));
        check("f1_pop2_cycle", qi(pop_cyc, 2), 32'(c0 + 2));
        check("f1_push_count", tx_got.size(), 1);
        check("f1_push_latency", qi(push_cyc, 0), 32'(c0 + 4));
        check("f1_result", q8(tx_got, 0), 32'h08);
        check("f1_alu_a", s_a, 32'h05);
        check("f1_alu_b", s_b, 32'h03);
        check("f1_alu_op", s_op, 32'h20);
        check("f1_idle", s_busy, 0);

        // TX full held for 10 cycles in SEND.
        tx_got.delete();
        tx_full_flag = 1'b1;
        rx_q = '{8'h05, 8'h03, 8'h20};
        repeat (4) step();
        repeat (10) step();
        check("full_no_push", tx_got.size(), 0);
        check("full_busy", s_busy, 1);
        tx_full_flag = 1'b0;
        step();
        check("full_release_push", s_wr, 1);
        check("full_release_data", s_wdata, 32'h08);
        step();
        check("full_idle", s_busy, 0);

        // Partial frame: only A arrives, then TO empty cycles in WAIT_B.
        tx_got.delete();
        to0 = to_cnt;
        rx_q = '{8'h11};
        step();
        repeat (TO) step();
        check("to_busy_last_wait", s_busy, 1);
        check("to_not_early", to_cnt - to0, 0);
        step();
        check("to_pulse", s_timeout, 1);
        check("to_idle", s_busy, 0);
        step();
        check("to_pulse_once", to_cnt - to0, 1);
        rx_q = '{8'h02, 8'h02, 8'hE0};
        repeat (6) step();
        check("to_next_result", q8(tx_got, 0), 32'h04);
        check("to_next_count", tx_got.size(), 1);

        // B and opcode each arrive on the expiry cycle: byte wins, timer restarts for opcode.
        tx_got.delete();
        to0 = to_cnt;
        rx_q = '{8'h07};
        step();
        repeat (TO - 1) step();
        rx_q.push_back(8'h09);
        step();
        check("exp_b_popped", s_rd, 1);
        repeat (TO - 1) step();
        rx_q.push_back(8'h20);
        step();
        check("exp_op_popped", s_rd, 1);
        repeat (3) step();
        check("exp_no_timeout", to_cnt - to0, 0);
        check("exp_result", q8(tx_got, 0), 32'h10);

        // Two frames back to back.
        pop_cyc.delete(); push_cyc.delete(); tx_got.delete();
        c0 = cyc;
        rx_q = '{8'h01, 8'h02, 8'h20, 8'h09, 8'h04, 8'h22};
        repeat (12) step();
        check("b2b_pop_count", pop_cyc.size(), 6);
        for (int i = 0; i < 6; i++) check("b2b_pop_cycle", qi(pop_cyc, i), 32'(c0 + exp_pops[i]));
        for (int i = 0; i < 2; i++) check("b2b_push_cycle", qi(push_cyc, i), 32'(c0 + exp_push[i]));
        check("b2b_result0", q8(tx_got, 0), 32'h03);
        check("b2b_result1", q8(tx_got, 1), 32'h05);

        // Reset while in WAIT_OP with the opcode present.
        tx_got.delete();
        rx_q = '{8'hAA, 8'hBB};
        repeat (2) step();
        rx_q.push_back(8'h20);
        i_reset = 1'b0;
        step();
        check("midrst_no_pop", s_rd, 0);
        check("midrst_rx_kept", rx_q.size(), 1);
        i_reset = 1'b1;
        hold_rx = 1'b1;
        step();
        check("midrst_busy", s_busy, 0);
        check("midrst_a", s_a, 0);
        check("midrst_b", s_b, 0);
        check("midrst_op", s_op, 0);
        check("midrst_wdata", s_wdata, 0);
        rx_q.delete();
        hold_rx = 1'b0;
        repeat (3) step();
        check("midrst_no_push", tx_got.size(), 0);

        // Random frames with RX stalls shorter than the timeout and random TX backpressure.
        tx_got.delete();
        exp_q.delete();
        to0 = to_cnt;
        for (int f = 0; f < 40; f++) begin
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            op = ops[$urandom_range(0, 6)];
            rx_q.push_back(a);
            rx_q.push_back(b);
            rx_q.push_back({2'($urandom_range(0, 3)), op});
            exp_q.push_back(ref_alu(a, b, op));
        end
        guard = 0;
        stall_run = 0;
        while (tx_got.size() < 40 && guard < 5000) begin
            hold_rx = ($urandom_range(0, 3) == 0) && (stall_run < 8);
            stall_run = hold_rx ? stall_run + 1 : 0;
            tx_full_flag = ($urandom_range(0, 2) == 0);
            step();
            guard++;
        end
        hold_rx = 1'b0;
        tx_full_flag = 1'b0;
        check("rand_done_in_budget", tx_got.size(), 40);
        for (int i = 0; i < 40; i++) check("rand_result", q8(tx_got, i), q8(exp_q, i));
        check("rand_no_timeout", to_cnt - to0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
